pixel_readout_capture: RTL and testbench

Downstream consumer of the exposure/readout controller's NRE_1, NRE_2, ADC and Erase strobes.
- Captures the external ADC conversion result on each ADC pulse and tags it with the pixel being read (pixel 1 when NRE_1 low, pixel 2 when NRE_2 low).
- Checks the frame sequence and buffers samples in a small FIFO.
- Presents samples on a valid/ready stream toward the display/serial stage.

---
 rtl/pixel_cam_pkg.sv | 14 +
 rtl/pixel_sample_fifo.sv | 51 +++++
 rtl/pixel_readout_capture.sv | 152 +++++++++++++++
 tb/tb_pixel_readout_capture.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_cam_pkg.sv
// Shared types and constants for the pixel readout capture block.
package pixel_cam_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic PIX_ID_1 = 1'b0;
    localparam logic PIX_ID_2 = 1'b1;

    typedef enum logic {
        S_PIX1 = 1'b0,
        S_PIX2 = 1'b1
    } pix_state_e;

endpackage

// File: rtl/pixel_sample_fifo.sv
// Synchronous sample FIFO. A push while full is accepted only if a pop
// happens in the same cycle. Reads come straight from the head entry, so
// data written into an empty FIFO becomes visible on the following cycle.
module pixel_sample_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array; contents need no reset since empty_o qualifies the head.
    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/pixel_readout_capture.sv
// Captures ADC results on each ADC rising edge, tags them with the active
// pixel, checks the pixel-1/pixel-2 frame order and streams samples out of
// a small FIFO on a valid/ready interface.
// Optional build macro PIXEL_BLACK_LEVEL_EN adds a Black_level input that is
// subtracted (saturating at zero) from each captured sample.
module pixel_readout_capture
    import pixel_cam_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int FCNT_W     = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              NRE_1,
    input  logic              NRE_2,
    input  logic              ADC,
    input  logic              Erase,
    input  logic [DATA_W-1:0] Adc_data,
`ifdef PIXEL_BLACK_LEVEL_EN
    input  logic [DATA_W-1:0] Black_level,
`endif
    input  logic              Out_ready,
    input  logic              Err_clr,
    output logic              Pix_valid,
    output logic [DATA_W-1:0] Pix_data,
    output logic              Pix_id,
    output logic              Frame_done,
    output logic [FCNT_W-1:0] Frame_count,
    output logic              Overflow,
    output logic              Seq_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    pix_state_e        state_q, state_d;
    logic              adc_q;
    logic              cap, sel_pix1, sel_pix2;
    logic              push_req, seq_evt, frame_evt, ovf_evt, pop;
    logic              cap_id;
    logic [DATA_W-1:0] sample_data;
    logic              frame_done_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic              overflow_q, seq_err_q;

    logic [DATA_W:0]   fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [AW:0]       fifo_cnt_unused;

    assign cap      = ADC & ~adc_q;
    assign sel_pix1 = ~NRE_1 &  NRE_2;
    assign sel_pix2 =  NRE_1 & ~NRE_2;
    assign cap_id   = sel_pix2 ? PIX_ID_2 : PIX_ID_1;

`ifdef PIXEL_BLACK_LEVEL_EN
    assign sample_data = (Adc_data > Black_level) ? (Adc_data - Black_level) : '0;
`else
    assign sample_data = Adc_data;
`endif

    // ADC edge detector and frame-sequence state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            adc_q   <= 1'b0;
            state_q <= S_PIX1;
        end else begin
            adc_q   <= ADC;
            state_q <= state_d;
        end
    end

    // Frame sequencing: decide push, error and frame-completion events per capture.
    always_comb begin
        state_d   = state_q;
        push_req  = 1'b0;
        seq_evt   = 1'b0;
        frame_evt = 1'b0;
        case (state_q)
            S_PIX1: begin
                if (cap) begin
                    if (sel_pix1) begin
                        push_req = 1'b1;
                        state_d  = S_PIX2;
                    end else begin
                        seq_evt  = 1'b1;
                    end
                end
            end
            S_PIX2: begin
                if (cap) begin
                    if (sel_pix2) begin
                        push_req  = 1'b1;
                        frame_evt = 1'b1;
                        state_d   = S_PIX1;
                    end else if (sel_pix1) begin
                        // Early pixel-1 sample restarts the frame.
                        push_req  = 1'b1;
                        seq_evt   = 1'b1;
                    end else begin
                        seq_evt   = 1'b1;
                    end
                end else if (Erase) begin
                    seq_evt = 1'b1;
                    state_d = S_PIX1;
                end
            end
            default: state_d = S_PIX1;
        endcase
    end

    assign pop     = ~fifo_empty & Out_ready;
    assign ovf_evt = push_req & fifo_full & ~pop;

    // Frame counter, done pulse and sticky error flags; new errors beat Err_clr.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            overflow_q   <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            frame_done_q <= frame_evt;
            frame_cnt_q  <= frame_cnt_q + FCNT_W'(frame_evt);
            overflow_q   <= (overflow_q & ~Err_clr) | ovf_evt;
            seq_err_q    <= (seq_err_q  & ~Err_clr) | seq_evt;
        end
    end

    pixel_sample_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .push_i  (push_req),
        .pop_i   (pop),
        .wdata_i ({cap_id, sample_data}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt_unused)
    );

    assign Pix_valid   = ~fifo_empty;
    assign Pix_data    = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
    assign Pix_id      = fifo_empty ? 1'b0 : fifo_rdata[DATA_W];
    assign Frame_done  = frame_done_q;
    assign Frame_count = frame_cnt_q;
    assign Overflow    = overflow_q;
    assign Seq_err     = seq_err_q;

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Bench for pixel_readout_capture: directed scenarios plus random traffic,
// all compared every cycle against a queue-based reference model.
module tb_pixel_readout_capture;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int FW    = 8;

    logic          Clk = 1'b0;
    logic          Reset, NRE_1, NRE_2, ADC, Erase, Out_ready, Err_clr;
    logic [DW-1:0] Adc_data;
`ifdef PIXEL_BLACK_LEVEL_EN
    logic [DW-1:0] Black_level;
`endif
    logic          Pix_valid, Pix_id, Frame_done, Overflow, Seq_err;
    logic [DW-1:0] Pix_data;
    logic [FW-1:0] Frame_count;

    pixel_readout_capture #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .FCNT_W(FW)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .NRE_1       (NRE_1),
        .NRE_2       (NRE_2),
        .ADC         (ADC),
        .Erase       (Erase),
        .Adc_data    (Adc_data),
`ifdef PIXEL_BLACK_LEVEL_EN
        .Black_level (Black_level),
`endif
        .Out_ready   (Out_ready),
        .Err_clr     (Err_clr),
        .Pix_valid   (Pix_valid),
        .Pix_data    (Pix_data),
        .Pix_id      (Pix_id),
        .Frame_done  (Frame_done),
        .Frame_count (Frame_count),
        .Overflow    (Overflow),
        .Seq_err     (Seq_err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } ent_t;

    // Reference model state
    ent_t          mq[$];
    bit            m_pix2, m_adc, m_fdone, m_ovf, m_seq;
    logic [FW-1:0] m_fcnt;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pop  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef PIXEL_BLACK_LEVEL_EN
        return (d > Black_level) ? d - Black_level : '0;
`else
        return d;
`endif
    endfunction

    // One clock of the reference behaviour, using the inputs now applied.
    task automatic model_step();
        bit   cap, pop, push, nseq, novf;
        ent_t e;
        if (Reset) begin
            mq.delete();
            m_pix2 = 0; m_adc = 0; m_fdone = 0; m_ovf = 0; m_seq = 0; m_fcnt = '0;
            return;
        end
        cap = ADC && !m_adc;
        pop = (mq.size() > 0) && Out_ready;
        push = 0; nseq = 0; novf = 0; m_fdone = 0;
        e.id = 1'b0;
        e.data = stored(Adc_data);
        if (cap) begin
            if (NRE_1 == NRE_2) nseq = 1;
            else if (!NRE_1) begin
                e.id = 1'b0; push = 1;
                if (m_pix2) nseq = 1;
                m_pix2 = 1;
            end else begin
                e.id = 1'b1;
                if (!m_pix2) nseq = 1;
                else begin
                    push = 1; m_fdone = 1; m_fcnt = m_fcnt + 1'b1; m_pix2 = 0;
                end
            end
        end else if (m_pix2 && Erase) begin
            nseq = 1; m_pix2 = 0;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else novf = 1;
        end
        m_ovf = (m_ovf && !Err_clr) || novf;
        m_seq = (m_seq && !Err_clr) || nseq;
        m_adc = ADC;
    endtask

    // Advance one clock and compare every output with the model.
    task automatic tick();
        if (Pix_valid && Out_ready) n_pop++;
        model_step();
        @(posedge Clk);
        #1;
        chk("valid", 32'(Pix_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("data", 32'(Pix_data), 32'(mq[0].data));
            chk("id", 32'(Pix_id), 32'(mq[0].id));
        end
        chk("frame_done", 32'(Frame_done), 32'(m_fdone));
        chk("frame_count", 32'(Frame_count), 32'(m_fcnt));
        chk("overflow", 32'(Overflow), 32'(m_ovf));
        chk("seq_err", 32'(Seq_err), 32'(m_seq));
    endtask

    task automatic quiet(input bit rdy);
        ADC = 0; NRE_1 = 1; NRE_2 = 1; Erase = 0; Err_clr = 0; Out_ready = rdy; Reset = 0;
    endtask

    task automatic idle(input int n, input bit rdy);
        quiet(rdy);
        repeat (n) tick();
    endtask

    task automatic adc_on(input bit id, input logic [DW-1:0] d, input bit rdy);
        quiet(rdy);
        ADC = 1; NRE_1 = id; NRE_2 = !id; Adc_data = d;
        tick();
    endtask

    task automatic sample(input bit id, input logic [DW-1:0] d, input bit rdy);
        adc_on(id, d, rdy);
        idle(1, rdy);
    endtask

    task automatic clr();
        quiet(Out_ready);
        Err_clr = 1;
        tick();
        Err_clr = 0;
    endtask

    task automatic do_reset();
        quiet(0);
        Reset = 1;
        tick();
        Reset = 0;
    endtask

    initial begin
        Reset = 1; NRE_1 = 1; NRE_2 = 1; ADC = 0; Erase = 0;
        Out_ready = 0; Err_clr = 0; Adc_data = '0;
`ifdef PIXEL_BLACK_LEVEL_EN
        Black_level = '0;
`endif
        tick(); tick();
        idle(2, 1);
        chk("rst_valid", 32'(Pix_valid), 0);
        chk("rst_fcnt", 32'(Frame_count), 0);
        chk("rst_flags", {30'd0, Overflow, Seq_err}, 0);

        // Normal frame
        adc_on(0, 8'h5A, 1);
        chk("nf_valid1", 32'(Pix_valid), 1);
        chk("nf_data1", 32'(Pix_data), 32'h5A);
        chk("nf_id1", 32'(Pix_id), 0);
        idle(1, 1);
        adc_on(1, 8'hC3, 1);
        chk("nf_data2", 32'(Pix_data), 32'hC3);
        chk("nf_id2", 32'(Pix_id), 1);
        chk("nf_done", 32'(Frame_done), 1);
        chk("nf_fcnt", 32'(Frame_count), 1);
        idle(1, 1);
        chk("nf_done_pulse", 32'(Frame_done), 0);
        chk("nf_noerr", {30'd0, Overflow, Seq_err}, 0);

        // Backpressure and overflow
        for (int k = 0; k < 5; k++) sample(k[0], 8'(8'h11 * (k + 1)), 0);
        chk("ovf_set", 32'(Overflow), 1);
        n_pop = 0;
        idle(8, 1);
        chk("ovf_pops", 32'(n_pop), 4);
        clr();
        chk("ovf_clr", 32'(Overflow), 0);
        sample(1, 8'h66, 1);

        // Sequence errors
        sample(1, 8'h77, 1);
        chk("seq_p2_first", 32'(Seq_err), 1);
        chk("seq_p2_nopush", 32'(Pix_valid), 0);
        clr();
        quiet(1); ADC = 1; NRE_1 = 0; NRE_2 = 0; tick();
        idle(1, 1);
        chk("seq_both_low", 32'(Seq_err), 1);
        clr();
        sample(0, 8'h21, 1);
        quiet(1); Erase = 1; tick();
        chk("seq_erase", 32'(Seq_err), 1);
        clr();
        adc_on(0, 8'h22, 0);
        chk("seq_restart_data", 32'(Pix_data), 32'h22);
        chk("seq_restart_ok", 32'(Seq_err), 0);
        idle(2, 1);
        sample(1, 8'h23, 1);

        // Long ADC pulse: one capture only
        quiet(0); ADC = 1; NRE_1 = 0; Adc_data = 8'h3C;
        repeat (3) tick();
        n_pop = 0;
        idle(4, 1);
        chk("long_pops", 32'(n_pop), 1);
        sample(1, 8'h3D, 1);

        // Full FIFO with a simultaneous pop
        for (int k = 0; k < 4; k++) sample(k[0], 8'(8'h80 + k), 0);
        adc_on(0, 8'h90, 1);
        chk("full_pop_noovf", 32'(Overflow), 0);
        idle(6, 1);
        sample(1, 8'h91, 1);

        // Frame counter wrap
        do_reset();
        for (int f = 0; f < 256; f++) begin
            sample(0, 8'(f), 1);
            sample(1, 8'(~f), 1);
        end
        chk("wrap_fcnt", 32'(Frame_count), 0);

        // Reset with samples buffered and a flag set
        sample(0, 8'h41, 0);
        sample(1, 8'h42, 0);
        sample(1, 8'h43, 0);
        chk("pre_rst_seq", 32'(Seq_err), 1);
        do_reset();
        chk("mid_rst_valid", 32'(Pix_valid), 0);
        chk("mid_rst_flags", {29'd0, Overflow, Seq_err, Frame_done}, 0);
        chk("mid_rst_fcnt", 32'(Frame_count), 0);

`ifdef PIXEL_BLACK_LEVEL_EN
        Black_level = 8'h10;
        adc_on(0, 8'h08, 0);
        chk("bl_sat", 32'(Pix_data), 0);
        do_reset();
        adc_on(0, 8'h30, 0);
        chk("bl_sub", 32'(Pix_data), 32'h20);
        do_reset();
`endif

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 9));
            ADC       = ($urandom_range(0, 2) == 0);
            NRE_1     = !(r < 4 || r == 8);
            NRE_2     = !((r >= 4 && r < 8) || r == 8);
            Erase     = ($urandom_range(0, 7) == 0);
            Out_ready = ($urandom_range(0, 2) != 0);
            Err_clr   = ($urandom_range(0, 15) == 0);
            Reset     = ($urandom_range(0, 199) == 0);
            Adc_data  = 8'($urandom);
`ifdef PIXEL_BLACK_LEVEL_EN
            Black_level = 8'($urandom_range(0, 63));
`endif
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
